// File: rtl/tron_pkg.sv
// ---------------------------------------------------------------------------
// tron_pkg
// Shared types for the light-cycle match sequencer.
//   game_state_t  : encoding of the top-level game-state FSM that drives the
//                   sequencer's Game_State input
//   match_state_t : internal states of match_controller
//   timer_width() : bit width of the shared frame down-counter
// ---------------------------------------------------------------------------
package tron_pkg;

  typedef enum logic [2:0] {
    MENU          = 3'd0,
    ROUND_PAUSED  = 3'd1,
    ROUND_STARTED = 3'd2,
    BLUE_WINS     = 3'd3,
    RED_WINS      = 3'd4
  } game_state_t;

  typedef enum logic [2:0] {
    IDLE,
    COUNTDOWN,
    PLAY,
    ROUND_END,
    WAIT_EXIT
  } match_state_t;

  // The counter only ever holds (frames - 1), so $clog2 of the larger frame
  // count is enough; floor at 1 bit so a 1-frame setting still elaborates.
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/match_controller_frame_timer.sv
// ---------------------------------------------------------------------------
// frame_timer
// Loadable down-counter measuring video frames. Load wins over tick; the
// count stops at zero.
//   Clk      : system clock
//   Reset_n  : asynchronous active-low reset (count cleared to 0)
//   load     : load load_val this cycle
//   load_val : value to load
//   tick     : decrement by one (ignored at zero)
//   zero     : count is zero
// ---------------------------------------------------------------------------
module frame_timer #(
  parameter int W = 7
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (tick && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero = (r_count == '0);

endmodule

// File: rtl/match_controller.sv
// ---------------------------------------------------------------------------
// match_controller
// Round/match sequencer for the two-player light-cycle game: runs the 3-2-1
// countdown, gates motion, scores crashes once per frame and reports the
// round/match result back to the game-state FSM.
//   Clk, Reset_n           : clock, asynchronous active-low reset
//   frame_tick             : one-cycle pulse per video frame
//   Game_State             : top-level game state
//   blue_crash, red_crash  : collision levels, valid on frame_tick
//   motion_en              : players may advance
//   countdown              : digit shown during countdown (3,2,1; else 0)
//   blue_score, red_score  : rounds won, saturating at WIN_SCORE
//   Reset_Round            : pulse, round over and match continues
//   Blue_W, Red_W          : pulse, match won
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for Game_State == ROUND_STARTED
// COUNTDOWN | showing 3,2,1, COUNT_FRAMES frames per digit, motion held
// PLAY      | players moving, crashes sampled on frame_tick
// ROUND_END | holding END_FRAMES frames after a crash, then result pulse
// WAIT_EXIT | result issued, waiting for Game_State to leave ROUND_STARTED
// ---------------------------------------------------------------------------
module match_controller
  import tron_pkg::*;
#(
  parameter int WIN_SCORE    = 3,
  parameter int COUNT_FRAMES = 60,
  parameter int END_FRAMES   = 90,
  parameter int SCORE_W      = 4
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_tick,
  input  game_state_t        Game_State,
  input  logic               blue_crash,
  input  logic               red_crash,
  output logic               motion_en,
  output logic [1:0]         countdown,
  output logic [SCORE_W-1:0] blue_score,
  output logic [SCORE_W-1:0] red_score,
  output logic               Reset_Round,
  output logic               Blue_W,
  output logic               Red_W
);

  localparam int TW = timer_width(COUNT_FRAMES, END_FRAMES);
  localparam logic [TW-1:0]      CNT_LOAD = TW'(COUNT_FRAMES - 1);
  localparam logic [TW-1:0]      END_LOAD = TW'(END_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);

  if ((WIN_SCORE < 1) || (WIN_SCORE > 15) || (WIN_SCORE > (2 ** SCORE_W) - 1)) begin : g_bad_score_w
    $error("match_controller: WIN_SCORE must be 1..15 and fit in SCORE_W bits");
  end

  match_state_t       r_state;
  logic [1:0]         r_countdown;
  logic               r_motion_en;
  logic [SCORE_W-1:0] r_blue_score;
  logic [SCORE_W-1:0] r_red_score;
  logic               r_reset_round;
  logic               r_blue_w;
  logic               r_red_w;

  logic               w_abort;
  logic               w_crash;
  logic               w_zero;
  logic               w_load;
  logic               w_tick;
  logic [TW-1:0]      w_load_val;

  // Leaving ROUND_STARTED mid-round cancels it without a result pulse.
  assign w_abort = (Game_State != ROUND_STARTED) &&
                   ((r_state == COUNTDOWN) || (r_state == PLAY) || (r_state == ROUND_END));
  assign w_crash = frame_tick && (blue_crash || red_crash);

  // Timer loads on state entry (and per countdown digit); a tick in the
  // entry cycle is swallowed because load wins inside the timer.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = CNT_LOAD;
    w_tick     = 1'b0;
    if (!w_abort) begin
      case (r_state)
        IDLE:      w_load = (Game_State == ROUND_STARTED);
        COUNTDOWN: begin
          if (frame_tick && !w_zero)                        w_tick = 1'b1;
          else if (frame_tick && (r_countdown > 2'd1))      w_load = 1'b1;
        end
        PLAY: begin
          if (w_crash) begin
            w_load     = 1'b1;
            w_load_val = END_LOAD;
          end
        end
        ROUND_END: w_tick = frame_tick && !w_zero;
        default:   ;
      endcase
    end
  end

  frame_timer #(.W(TW)) u_frame_timer (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .load     (w_load),
    .load_val (w_load_val),
    .tick     (w_tick),
    .zero     (w_zero)
  );

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s >= WIN) ? s : s + 1'b1;
  endfunction

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state       <= IDLE;
      r_countdown   <= 2'd0;
      r_motion_en   <= 1'b0;
      r_blue_score  <= '0;
      r_red_score   <= '0;
      r_reset_round <= 1'b0;
      r_blue_w      <= 1'b0;
      r_red_w       <= 1'b0;
    end else begin
      r_reset_round <= 1'b0;
      r_blue_w      <= 1'b0;
      r_red_w       <= 1'b0;
      if (w_abort) begin
        r_state     <= IDLE;
        r_motion_en <= 1'b0;
        r_countdown <= 2'd0;
      end else begin
        case (r_state)
          IDLE: begin
            r_motion_en <= 1'b0;
            if (Game_State == ROUND_STARTED) begin
              r_state     <= COUNTDOWN;
              r_countdown <= 2'd3;
            end
          end
          COUNTDOWN: begin
            if (frame_tick && w_zero) begin
              if (r_countdown > 2'd1) begin
                r_countdown <= r_countdown - 2'd1;
              end else begin
                r_countdown <= 2'd0;
                r_motion_en <= 1'b1;
                r_state     <= PLAY;
              end
            end
          end
          PLAY: begin
            if (w_crash) begin
              // The crashing player's opponent takes the round; both = draw.
              if (blue_crash && !red_crash) r_red_score  <= sat_inc(r_red_score);
              if (red_crash && !blue_crash) r_blue_score <= sat_inc(r_blue_score);
              r_motion_en <= 1'b0;
              r_state     <= ROUND_END;
            end
          end
          ROUND_END: begin
            if (frame_tick && w_zero) begin
              if (r_blue_score >= WIN)     r_blue_w      <= 1'b1;
              else if (r_red_score >= WIN) r_red_w       <= 1'b1;
              else                         r_reset_round <= 1'b1;
              r_state <= WAIT_EXIT;
            end
          end
          WAIT_EXIT: begin
            if (Game_State != ROUND_STARTED) r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
      if (Game_State == MENU) begin
        r_blue_score <= '0;
        r_red_score  <= '0;
      end
    end
  end

  assign motion_en   = r_motion_en;
  assign countdown   = r_countdown;
  assign blue_score  = r_blue_score;
  assign red_score   = r_red_score;
  assign Reset_Round = r_reset_round;
  assign Blue_W      = r_blue_w;
  assign Red_W       = r_red_w;

endmodule

// File: tb/tb_match_controller.sv
// ---------------------------------------------------------------------------
// tb_match_controller
// Directed scenarios followed by random Game_State / frame_tick / crash
// traffic. Expected outputs come from a frame-counting model of the match
// rules (ticks elapsed per phase, digit = 3 - ticks/COUNT_FRAMES).
// ---------------------------------------------------------------------------
module tb_match_controller;
  import tron_pkg::*;

  localparam int CF = 2;
  localparam int EF = 2;
  localparam int WS = 3;
  localparam int SW = 4;

  localparam int P_IDLE = 0;
  localparam int P_CD   = 1;
  localparam int P_PLAY = 2;
  localparam int P_END  = 3;
  localparam int P_WAIT = 4;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          frame_tick;
  game_state_t   Game_State;
  logic          blue_crash;
  logic          red_crash;
  logic          motion_en;
  logic [1:0]    countdown;
  logic [SW-1:0] blue_score;
  logic [SW-1:0] red_score;
  logic          Reset_Round;
  logic          Blue_W;
  logic          Red_W;

  int n_checks = 0;
  int n_errors = 0;

  int            m_phase;
  int            m_ticks;
  logic          m_motion;
  logic [1:0]    m_count;
  logic [SW-1:0] m_blue;
  logic [SW-1:0] m_red;
  logic          m_rr;
  logic          m_bw;
  logic          m_rw;

  always #5 Clk = ~Clk;

  match_controller #(
    .WIN_SCORE    (WS),
    .COUNT_FRAMES (CF),
    .END_FRAMES   (EF),
    .SCORE_W      (SW)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_tick  (frame_tick),
    .Game_State  (Game_State),
    .blue_crash  (blue_crash),
    .red_crash   (red_crash),
    .motion_en   (motion_en),
    .countdown   (countdown),
    .blue_score  (blue_score),
    .red_score   (red_score),
    .Reset_Round (Reset_Round),
    .Blue_W      (Blue_W),
    .Red_W       (Red_W)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk($sformatf("%s motion_en", tag),   32'(motion_en),   32'(m_motion));
    chk($sformatf("%s countdown", tag),   32'(countdown),   32'(m_count));
    chk($sformatf("%s blue_score", tag),  32'(blue_score),  32'(m_blue));
    chk($sformatf("%s red_score", tag),   32'(red_score),   32'(m_red));
    chk($sformatf("%s Reset_Round", tag), 32'(Reset_Round), 32'(m_rr));
    chk($sformatf("%s Blue_W", tag),      32'(Blue_W),      32'(m_bw));
    chk($sformatf("%s Red_W", tag),       32'(Red_W),       32'(m_rw));
  endtask

  task automatic model_reset();
    m_phase  = P_IDLE;
    m_ticks  = 0;
    m_motion = 1'b0;
    m_count  = 2'd0;
    m_blue   = '0;
    m_red    = '0;
    m_rr     = 1'b0;
    m_bw     = 1'b0;
    m_rw     = 1'b0;
  endtask

  function automatic logic [SW-1:0] sat(input logic [SW-1:0] s);
    return (int'(s) >= WS) ? s : s + 1'b1;
  endfunction

  // One clock edge of match behaviour, given the inputs sampled at that edge.
  task automatic model_step(input game_state_t gs, input logic tk, input logic bc, input logic rc);
    bit in_round;
    m_rr = 1'b0;
    m_bw = 1'b0;
    m_rw = 1'b0;
    in_round = (m_phase == P_CD) || (m_phase == P_PLAY) || (m_phase == P_END);
    if (in_round && gs != ROUND_STARTED) begin
      m_phase  = P_IDLE;
      m_motion = 1'b0;
      m_count  = 2'd0;
    end else if (m_phase == P_IDLE) begin
      if (gs == ROUND_STARTED) begin
        m_phase = P_CD;
        m_ticks = 0;
        m_count = 2'd3;
      end
    end else if (m_phase == P_CD) begin
      if (tk) begin
        m_ticks++;
        if (m_ticks == 3 * CF) begin
          m_phase  = P_PLAY;
          m_count  = 2'd0;
          m_motion = 1'b1;
        end else begin
          m_count = 2'(3 - m_ticks / CF);
        end
      end
    end else if (m_phase == P_PLAY) begin
      if (tk && (bc || rc)) begin
        if (bc && !rc) m_red  = sat(m_red);
        if (rc && !bc) m_blue = sat(m_blue);
        m_phase  = P_END;
        m_ticks  = 0;
        m_motion = 1'b0;
      end
    end else if (m_phase == P_END) begin
      if (tk) begin
        m_ticks++;
        if (m_ticks == EF) begin
          if (int'(m_blue) >= WS)     m_bw = 1'b1;
          else if (int'(m_red) >= WS) m_rw = 1'b1;
          else                        m_rr = 1'b1;
          m_phase = P_WAIT;
        end
      end
    end else if (m_phase == P_WAIT) begin
      if (gs != ROUND_STARTED) m_phase = P_IDLE;
    end
    if (gs == MENU) begin
      m_blue = '0;
      m_red  = '0;
    end
  endtask

  task automatic cycle(input game_state_t gs, input logic tk, input logic bc, input logic rc,
                       input string tag);
    Game_State = gs;
    frame_tick = tk;
    blue_crash = bc;
    red_crash  = rc;
    @(posedge Clk);
    model_step(gs, tk, bc, rc);
    #1;
    check_all(tag);
  endtask

  // Enter a round, run the full countdown, crash, and hold until the pulse.
  task automatic play_round(input logic bc, input logic rc, input string tag);
    cycle(ROUND_STARTED, 1'b0, 1'b0, 1'b0, tag);
    repeat (3 * CF) cycle(ROUND_STARTED, 1'b1, 1'b0, 1'b0, tag);
    cycle(ROUND_STARTED, 1'b1, bc, rc, tag);
    repeat (EF) cycle(ROUND_STARTED, 1'b1, 1'b0, 1'b0, tag);
  endtask

  initial begin
    int seq[6];
    int r;
    seq = '{3, 3, 2, 2, 1, 1};

    Reset_n    = 1'b0;
    frame_tick = 1'b0;
    blue_crash = 1'b0;
    red_crash  = 1'b0;
    Game_State = MENU;
    model_reset();
    #2;
    check_all("reset");
    @(posedge Clk);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;

    // Countdown 3,3,2,2,1,1 with a tick every cycle, then motion.
    cycle(ROUND_STARTED, 1'b0, 1'b0, 1'b0, "sc2 enter");
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("sc2 digit %0d", i), 32'(countdown), 32'(seq[i]));
      cycle(ROUND_STARTED, 1'b1, 1'b0, 1'b0, "sc2 tick");
    end
    chk("sc2 motion after tick 6", 32'(motion_en), 32'd1);

    // Blue crashes: red scores, Reset_Round after END_FRAMES ticks.
    cycle(ROUND_STARTED, 1'b1, 1'b1, 1'b0, "sc3 crash");
    chk("sc3 red_score", 32'(red_score), 32'd1);
    chk("sc3 motion off", 32'(motion_en), 32'd0);
    cycle(ROUND_STARTED, 1'b1, 1'b0, 1'b0, "sc3 hold");
    chk("sc3 no early pulse", 32'(Reset_Round), 32'd0);
    cycle(ROUND_STARTED, 1'b1, 1'b0, 1'b0, "sc3 pulse");
    chk("sc3 Reset_Round", 32'(Reset_Round), 32'd1);
    chk("sc3 Blue_W", 32'(Blue_W), 32'd0);
    cycle(ROUND_STARTED, 1'b0, 1'b0, 1'b0, "sc3 after");
    chk("sc3 pulse one cycle", 32'(Reset_Round), 32'd0);
    cycle(ROUND_PAUSED, 1'b0, 1'b0, 1'b0, "sc3 exit");

    // Draw: no score change.
    play_round(1'b1, 1'b1, "sc4");
    chk("sc4 draw red", 32'(red_score), 32'd1);
    chk("sc4 draw blue", 32'(blue_score), 32'd0);
    chk("sc4 Reset_Round", 32'(Reset_Round), 32'd1);
    cycle(ROUND_PAUSED, 1'b0, 1'b0, 1'b0, "sc4 exit");

    // Reach 2/1 and reset asynchronously in the middle of PLAY.
    play_round(1'b0, 1'b1, "sc1 r1");
    cycle(ROUND_PAUSED, 1'b0, 1'b0, 1'b0, "sc1 exit");
    play_round(1'b0, 1'b1, "sc1 r2");
    cycle(ROUND_PAUSED, 1'b0, 1'b0, 1'b0, "sc1 exit");
    cycle(ROUND_STARTED, 1'b0, 1'b0, 1'b0, "sc1 enter");
    repeat (3 * CF) cycle(ROUND_STARTED, 1'b1, 1'b0, 1'b0, "sc1 cd");
    chk("sc1 blue before reset", 32'(blue_score), 32'd2);
    chk("sc1 motion before reset", 32'(motion_en), 32'd1);
    #2;
    Reset_n = 1'b0;
    model_reset();
    #1;
    check_all("sc1 async reset");
    chk("sc1 motion cleared", 32'(motion_en), 32'd0);
    #1;
    Reset_n = 1'b1;
    cycle(ROUND_STARTED, 1'b0, 1'b0, 1'b0, "sc1 restart");
    chk("sc1 countdown 3", 32'(countdown), 32'd3);
    cycle(ROUND_PAUSED, 1'b0, 1'b0, 1'b0, "sc1 leave");

    // Blue takes the match; WAIT_EXIT holds until Game_State changes.
    play_round(1'b0, 1'b1, "sc5 r1");
    cycle(ROUND_PAUSED, 1'b0, 1'b0, 1'b0, "sc5 exit");
    play_round(1'b0, 1'b1, "sc5 r2");
    cycle(ROUND_PAUSED, 1'b0, 1'b0, 1'b0, "sc5 exit");
    play_round(1'b0, 1'b1, "sc5 r3");
    chk("sc5 blue_score", 32'(blue_score), 32'd3);
    chk("sc5 Blue_W", 32'(Blue_W), 32'd1);
    chk("sc5 Reset_Round", 32'(Reset_Round), 32'd0);
    repeat (4) cycle(ROUND_STARTED, 1'b1, 1'b0, 1'b0, "sc5 wait");
    chk("sc5 Blue_W one pulse", 32'(Blue_W), 32'd0);
    chk("sc5 no retrigger", 32'(countdown), 32'd0);
    cycle(BLUE_WINS, 1'b0, 1'b0, 1'b0, "sc5 blue_wins");
    chk("sc5 score kept", 32'(blue_score), 32'd3);
    cycle(MENU, 1'b0, 1'b0, 1'b0, "sc5 menu");
    chk("sc5 menu clears", 32'(blue_score), 32'd0);

    // Abort during countdown, then restart.
    cycle(ROUND_STARTED, 1'b0, 1'b0, 1'b0, "sc6 enter");
    repeat (3) cycle(ROUND_STARTED, 1'b1, 1'b0, 1'b0, "sc6 cd");
    cycle(ROUND_PAUSED, 1'b0, 1'b0, 1'b0, "sc6 abort");
    chk("sc6 countdown cleared", 32'(countdown), 32'd0);
    chk("sc6 no pulse", 32'(Reset_Round), 32'd0);
    cycle(ROUND_STARTED, 1'b0, 1'b0, 1'b0, "sc6 reenter");
    chk("sc6 restart at 3", 32'(countdown), 32'd3);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      game_state_t gs;
      r = int'($urandom_range(0, 99));
      if (r < 88)      gs = ROUND_STARTED;
      else if (r < 94) gs = ROUND_PAUSED;
      else if (r < 97) gs = MENU;
      else if (r < 99) gs = BLUE_WINS;
      else             gs = RED_WINS;
      cycle(gs, ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 5) == 0), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
